// File: rtl/fsm_4_driver.sv
// fsm_4_driver: host-side sequencer for the fsm_4 arithmetic engine.
// Queues operand pairs, issues each one as reset/start/wait, checks the
// engine result against a locally computed golden value and reports a
// record per transaction along with saturating pass/fail tallies.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for a queued pair; pops it and latches operands/golden
// RST   | one-cycle engine restart pulse
// START | one-cycle engine start pulse; timeout counter cleared
// WAIT  | waiting for eng_done, bounded by TIMEOUT cycles
// RESP  | record presented on out_*; leaves when the consumer takes it
module fsm_4_driver #(
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_a,
    input  logic [31:0]      in_b,
    output logic             eng_reset,
    output logic             eng_start,
    output logic [31:0]      eng_a,
    output logic [31:0]      eng_b,
    input  logic             eng_done,
    input  logic [35:0]      eng_result,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [35:0]      out_result,
    output logic [35:0]      out_expected,
    output logic             out_mismatch,
    output logic             out_timeout,
    output logic [CNT_W-1:0] pass_count,
    output logic [CNT_W-1:0] fail_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int TW = $clog2(TIMEOUT) + 1;
    localparam logic [TW-1:0]    TMO_LAST = TW'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RST,
        S_START,
        S_WAIT,
        S_RESP
    } state_t;

    // E = ((A+B)*4 + B)/2 + (B/2 + A*4), everything 36-bit unsigned
    function automatic logic [35:0] golden(input logic [31:0] a, input logic [31:0] b);
        logic [35:0] a36;
        logic [35:0] b36;
        logic [35:0] lhs;
        logic [35:0] rhs;
        a36 = {4'b0000, a};
        b36 = {4'b0000, b};
        lhs = (((a36 + b36) << 2) + b36) >> 1;
        rhs = (b36 >> 1) + (a36 << 2);
        return lhs + rhs;
    endfunction

    logic [31:0]      mem_a [DEPTH];
    logic [31:0]      mem_b [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             push, pop;

    state_t           state_q, state_d;
    logic [31:0]      eng_a_q, eng_a_d;
    logic [31:0]      eng_b_q, eng_b_d;
    logic [35:0]      result_q, result_d;
    logic [35:0]      exp_q, exp_d;
    logic             mm_q, mm_d;
    logic             to_q, to_d;
    logic [TW-1:0]    tmo_q, tmo_d;
    logic [CNT_W-1:0] pass_q, pass_d;
    logic [CNT_W-1:0] fail_q, fail_d;

    // in_ready depends only on the registered count, so a full FIFO never
    // accepts in the same cycle it pops
    assign in_ready = (count_q < CW'(DEPTH));
    assign push     = in_valid && in_ready;
    assign pop      = (state_q == S_IDLE) && (count_q != '0);

    // FIFO pointer and occupancy next-state
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) wr_ptr_d = wr_ptr_q + AW'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // operand storage; contents are don't-care while unoccupied
    always_ff @(posedge clk) begin
        if (push) begin
            mem_a[wr_ptr_q] <= in_a;
            mem_b[wr_ptr_q] <= in_b;
        end
    end

    // transaction sequencing, record capture and strobe outputs
    always_comb begin
        state_d   = state_q;
        eng_a_d   = eng_a_q;
        eng_b_d   = eng_b_q;
        result_d  = result_q;
        exp_d     = exp_q;
        mm_d      = mm_q;
        to_d      = to_q;
        tmo_d     = tmo_q;
        pass_d    = pass_q;
        fail_d    = fail_q;
        eng_reset = 1'b0;
        eng_start = 1'b0;
        out_valid = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (pop) begin
                    state_d = S_RST;
                    eng_a_d = mem_a[rd_ptr_q];
                    eng_b_d = mem_b[rd_ptr_q];
                    exp_d   = golden(mem_a[rd_ptr_q], mem_b[rd_ptr_q]);
                end
            end
            S_RST: begin
                eng_reset = 1'b1;
                state_d   = S_START;
            end
            S_START: begin
                eng_start = 1'b1;
                tmo_d     = '0;
                state_d   = S_WAIT;
            end
            S_WAIT: begin
                tmo_d = tmo_q + TW'(1);
                if (eng_done) begin
                    state_d  = S_RESP;
                    result_d = eng_result;
                    to_d     = 1'b0;
                    mm_d     = (eng_result != exp_q);
                end else if (tmo_q == TMO_LAST) begin
                    state_d  = S_RESP;
                    result_d = '0;
                    to_d     = 1'b1;
                    mm_d     = 1'b1;
                end
            end
            S_RESP: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = S_IDLE;
                    if (mm_q) begin
                        if (fail_q != CNT_MAX) fail_d = fail_q + CNT_W'(1);
                    end else begin
                        if (pass_q != CNT_MAX) pass_d = pass_q + CNT_W'(1);
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // state and datapath registers with synchronous clear
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            eng_a_q  <= '0;
            eng_b_q  <= '0;
            result_q <= '0;
            exp_q    <= '0;
            mm_q     <= 1'b0;
            to_q     <= 1'b0;
            tmo_q    <= '0;
            pass_q   <= '0;
            fail_q   <= '0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            eng_a_q  <= eng_a_d;
            eng_b_q  <= eng_b_d;
            result_q <= result_d;
            exp_q    <= exp_d;
            mm_q     <= mm_d;
            to_q     <= to_d;
            tmo_q    <= tmo_d;
            pass_q   <= pass_d;
            fail_q   <= fail_d;
        end
    end

    assign eng_a        = eng_a_q;
    assign eng_b        = eng_b_q;
    assign out_result   = result_q;
    assign out_expected = exp_q;
    assign out_mismatch = mm_q;
    assign out_timeout  = to_q;
    assign pass_count   = pass_q;
    assign fail_count   = fail_q;

endmodule
